// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
// The state encoding is also visible to anything that probes the sequencer.
package mul_arb_pkg;

    localparam int OPERAND_W = 32;
    localparam int PRODUCT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mul32_share_arb_rr_pick.sv
// Combinational round-robin picker: finds the first request at or after the
// pointer, wrapping around, and reports it both one-hot and as an index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    // Scan offsets from the pointer; the first hit wins and later hits are masked.
    always_comb begin : pickScan
        logic            found;
        logic [ID_W-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mul32_share_arb.sv
// Round-robin sequencer that shares one variable-latency 32x32 multiplier
// between NUM_REQ clients and returns tagged, latency-stamped products.
module mul32_share_arb
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LAT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*OPERAND_W-1:0]   req_a,
    input  logic [NUM_REQ*OPERAND_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           mul_start,
    output logic [OPERAND_W-1:0]           mul_a,
    output logic [OPERAND_W-1:0]           mul_b,
    input  logic [PRODUCT_W-1:0]           mul_p,
    input  logic                           mul_valid,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [PRODUCT_W-1:0]           rsp_p,
    output logic [LAT_W-1:0]               rsp_lat,
    output logic                           busy,
    output logic                           spur_err
);

    localparam logic [LAT_W-1:0] LAT_MAX  = '1;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rrPtr_q, rrPtr_d;
    logic [ID_W-1:0]        ownerId_q, ownerId_d;
    logic [OPERAND_W-1:0]   mulA_q, mulA_d;
    logic [OPERAND_W-1:0]   mulB_q, mulB_d;
    logic [LAT_W-1:0]       latCnt_q, latCnt_d;
    logic [PRODUCT_W-1:0]   rspP_q, rspP_d;
    logic [ID_W-1:0]        rspId_q, rspId_d;
    logic [LAT_W-1:0]       rspLat_q, rspLat_d;
    logic                   spurErr_q, spurErr_d;

    logic [NUM_REQ-1:0]     pickGnt;
    logic [ID_W-1:0]        pickIdx;
    logic                   pickAny;
    logic [OPERAND_W-1:0]   selA;
    logic [OPERAND_W-1:0]   selB;
    logic [LAT_W-1:0]       latInc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_i (req_valid),
        .ptr_i (rrPtr_q),
        .gnt_o (pickGnt),
        .idx_o (pickIdx),
        .any_o (pickAny)
    );

    // One-hot AND-OR mux of the granted requester's operand slices.
    always_comb begin
        selA = '0;
        selB = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickGnt[i]) begin
                selA = selA | req_a[i*OPERAND_W +: OPERAND_W];
                selB = selB | req_b[i*OPERAND_W +: OPERAND_W];
            end
        end
    end

    assign latInc = (latCnt_q == LAT_MAX) ? LAT_MAX : latCnt_q + LAT_W'(1);

    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        ownerId_d = ownerId_q;
        mulA_d    = mulA_q;
        mulB_d    = mulB_q;
        latCnt_d  = latCnt_q;
        rspP_d    = rspP_q;
        rspId_d   = rspId_q;
        rspLat_d  = rspLat_q;
        spurErr_d = spurErr_q | (mul_valid && (state_q != WAIT));

        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    mulA_d    = selA;
                    mulB_d    = selB;
                    ownerId_d = pickIdx;
                    rrPtr_d   = (pickIdx == LAST_ID) ? '0 : pickIdx + ID_W'(1);
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                latCnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                latCnt_d = latInc;
                // The reported latency includes the completion cycle itself.
                if (mul_valid) begin
                    rspP_d   = mul_p;
                    rspId_d  = ownerId_q;
                    rspLat_d = latInc;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            ownerId_q <= '0;
            mulA_q    <= '0;
            mulB_q    <= '0;
            latCnt_q  <= '0;
            rspP_q    <= '0;
            rspId_q   <= '0;
            rspLat_q  <= '0;
            spurErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            ownerId_q <= ownerId_d;
            mulA_q    <= mulA_d;
            mulB_q    <= mulB_d;
            latCnt_q  <= latCnt_d;
            rspP_q    <= rspP_d;
            rspId_q   <= rspId_d;
            rspLat_q  <= rspLat_d;
            spurErr_q <= spurErr_d;
        end
    end

    // Grant is masked while reset is held so no client sees a transfer then.
    assign req_ready = (state_q == IDLE && !rst) ? pickGnt : '0;
    assign mul_start = (state_q == ISSUE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign mul_a     = mulA_q;
    assign mul_b     = mulB_q;
    assign rsp_p     = rspP_q;
    assign rsp_id    = rspId_q;
    assign rsp_lat   = rspLat_q;
    assign spur_err  = spurErr_q;

endmodule

// File: tb/tb_mul32_share_arb.sv
// Directed bench for mul32_share_arb: two instances (16-bit and 4-bit latency
// counters), each driven against a behavioural variable-latency multiplier.
module tb_mul32_share_arb;

    logic          clk;
    logic          rst;

    logic [3:0]    reqValid0;
    logic [127:0]  reqA0, reqB0;
    logic [3:0]    reqReady0;
    logic          mulStart0;
    logic [31:0]   mulA0, mulB0;
    logic [63:0]   mulP0;
    logic          mulValid0;
    logic          rspValid0;
    logic [1:0]    rspId0;
    logic [63:0]   rspP0;
    logic [15:0]   rspLat0;
    logic          busy0, spurErr0;

    logic [3:0]    reqValid1;
    logic [127:0]  reqA1, reqB1;
    logic [3:0]    reqReady1;
    logic          mulStart1;
    logic [31:0]   mulA1, mulB1;
    logic [63:0]   mulP1;
    logic          mulValid1;
    logic          rspValid1;
    logic [1:0]    rspId1;
    logic [63:0]   rspP1;
    logic [3:0]    rspLat1;
    logic          busy1, spurErr1;

    logic          spurInj;
    logic          modelValid0, modelValid1;
    logic          modelRun0, modelRun1;
    int            modelCnt0, modelCnt1;
    int            modelLat0, modelLat1;

    int            vectors;
    int            miscompares;

    mul32_share_arb #(.NUM_REQ(4), .ID_W(2), .LAT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid0), .req_a(reqA0), .req_b(reqB0), .req_ready(reqReady0),
        .mul_start(mulStart0), .mul_a(mulA0), .mul_b(mulB0),
        .mul_p(mulP0), .mul_valid(mulValid0),
        .rsp_valid(rspValid0), .rsp_id(rspId0), .rsp_p(rspP0), .rsp_lat(rspLat0),
        .busy(busy0), .spur_err(spurErr0)
    );

    mul32_share_arb #(.NUM_REQ(4), .ID_W(2), .LAT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid1), .req_a(reqA1), .req_b(reqB1), .req_ready(reqReady1),
        .mul_start(mulStart1), .mul_a(mulA1), .mul_b(mulB1),
        .mul_p(mulP1), .mul_valid(mulValid1),
        .rsp_valid(rspValid1), .rsp_id(rspId1), .rsp_p(rspP1), .rsp_lat(rspLat1),
        .busy(busy1), .spur_err(spurErr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: valid pulses exactly modelLat cycles after the start cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            modelValid0 <= 1'b0;
            modelRun0   <= 1'b0;
            modelCnt0   <= 0;
            mulP0       <= '0;
        end else begin
            modelValid0 <= 1'b0;
            if (mulStart0) begin
                modelRun0 <= 1'b1;
                modelCnt0 <= modelLat0 - 1;
                mulP0     <= 64'(mulA0) * 64'(mulB0);
            end else if (modelRun0) begin
                if (modelCnt0 <= 1) begin
                    modelValid0 <= 1'b1;
                    modelRun0   <= 1'b0;
                end else begin
                    modelCnt0 <= modelCnt0 - 1;
                end
            end
        end
    end

    // Same model for the narrow-counter instance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            modelValid1 <= 1'b0;
            modelRun1   <= 1'b0;
            modelCnt1   <= 0;
            mulP1       <= '0;
        end else begin
            modelValid1 <= 1'b0;
            if (mulStart1) begin
                modelRun1 <= 1'b1;
                modelCnt1 <= modelLat1 - 1;
                mulP1     <= 64'(mulA1) * 64'(mulB1);
            end else if (modelRun1) begin
                if (modelCnt1 <= 1) begin
                    modelValid1 <= 1'b1;
                    modelRun1   <= 1'b0;
                end else begin
                    modelCnt1 <= modelCnt1 - 1;
                end
            end
        end
    end

    assign mulValid0 = modelValid0 | spurInj;
    assign mulValid1 = modelValid1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitRsp0(output int n);
        n = 0;
        while (rspValid0 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("rsp0 arrives", 64'(rspValid0), 64'd1);
    endtask

    task automatic waitRsp1(output int n);
        n = 0;
        while (rspValid1 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("rsp1 arrives", 64'(rspValid1), 64'd1);
    endtask

    // One isolated transaction on dut0 from an IDLE cycle, checked end to end.
    task automatic applyStimulus(input int id, input logic [31:0] a,
                                 input logic [31:0] b, input int lat);
        int n;
        modelLat0 = lat;
        reqA0[id*32 +: 32] = a;
        reqB0[id*32 +: 32] = b;
        reqValid0 = 4'b0001 << id;
        #1;
        checkOutput("grant one-hot", 64'(reqReady0), 64'(4'b0001 << id));
        tick();
        checkOutput("start in ISSUE", 64'(mulStart0), 64'd1);
        checkOutput("ready low in ISSUE", 64'(reqReady0), 64'd0);
        checkOutput("latched mul_a", 64'(mulA0), 64'(a));
        checkOutput("latched mul_b", 64'(mulB0), 64'(b));
        reqValid0 = 4'b0000;
        tick();
        checkOutput("start one cycle", 64'(mulStart0), 64'd0);
        checkOutput("busy in WAIT", 64'(busy0), 64'd1);
        waitRsp0(n);
        checkOutput("wait cycles", 64'(n), 64'(lat));
        checkOutput("rsp id", 64'(rspId0), 64'(id));
        checkOutput("rsp product", rspP0, 64'(a) * 64'(b));
        checkOutput("rsp latency", 64'(rspLat0), 64'(lat));
        tick();
        checkOutput("rsp pulse ends", 64'(rspValid0), 64'd0);
        checkOutput("rsp product held", rspP0, 64'(a) * 64'(b));
        checkOutput("idle after resp", 64'(busy0), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   n;
        int   g;
        logic held;
        logic sawRsp;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        spurInj     = 1'b0;
        reqValid0   = '0;
        reqA0       = '0;
        reqB0       = '0;
        reqValid1   = '0;
        reqA1       = '0;
        reqB1       = '0;
        modelLat0   = 5;
        modelLat1   = 5;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ready", 64'(reqReady0), 64'd0);
        checkOutput("reset start", 64'(mulStart0), 64'd0);
        checkOutput("reset mul_a", 64'(mulA0), 64'd0);
        checkOutput("reset rsp_valid", 64'(rspValid0), 64'd0);
        checkOutput("reset rsp_p", rspP0, 64'd0);
        checkOutput("reset busy", 64'(busy0), 64'd0);
        checkOutput("reset spur", 64'(spurErr0), 64'd0);
        rst = 1'b0;
        tick();

        // Single request, all-ones operands.
        applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        checkOutput("all-ones product", rspP0, 64'hFFFF_FFFE_0000_0001);

        // Spurious completion while idle.
        spurInj = 1'b1;
        #1;
        checkOutput("spur no rsp", 64'(rspValid0), 64'd0);
        tick();
        spurInj = 1'b0;
        checkOutput("spur flagged", 64'(spurErr0), 64'd1);
        checkOutput("spur stays idle", 64'(busy0), 64'd0);
        tick();
        tick();
        checkOutput("spur sticky", 64'(spurErr0), 64'd1);
        applyStimulus(3, 32'd7, 32'd6, 5);
        checkOutput("spur still sticky", 64'(spurErr0), 64'd1);

        // Reset in the middle of WAIT.
        modelLat0 = 20;
        reqA0[2*32 +: 32] = 32'd3;
        reqB0[2*32 +: 32] = 32'd3;
        reqValid0 = 4'b0100;
        #1;
        checkOutput("pre-reset grant", 64'(reqReady0), 64'b0100);
        tick();
        tick();
        tick();
        checkOutput("in WAIT before reset", 64'(busy0), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid reset busy", 64'(busy0), 64'd0);
        checkOutput("mid reset ready", 64'(reqReady0), 64'd0);
        checkOutput("mid reset start", 64'(mulStart0), 64'd0);
        checkOutput("mid reset mul_a", 64'(mulA0), 64'd0);
        checkOutput("mid reset mul_b", 64'(mulB0), 64'd0);
        checkOutput("mid reset rsp_id", 64'(rspId0), 64'd0);
        checkOutput("mid reset rsp_p", rspP0, 64'd0);
        checkOutput("mid reset rsp_lat", 64'(rspLat0), 64'd0);
        checkOutput("mid reset spur", 64'(spurErr0), 64'd0);
        reqValid0 = 4'b0000;
        tick();
        rst = 1'b0;
        sawRsp = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            sawRsp = sawRsp | rspValid0;
        end
        checkOutput("no rsp after reset", 64'(sawRsp), 64'd0);

        // All four requesting continuously; pointer must be back at 0.
        modelLat0 = 5;
        for (int i = 0; i < 4; i++) begin
            reqA0[i*32 +: 32] = 32'(i + 1);
            reqB0[i*32 +: 32] = 32'h10;
        end
        reqValid0 = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            checkOutput("rr grant", 64'(reqReady0), 64'(4'b0001 << g));
            tick();
            waitRsp0(n);
            checkOutput("rr turnaround", 64'(n), 64'd6);
            checkOutput("rr rsp id", 64'(rspId0), 64'(g));
            checkOutput("rr rsp product", rspP0, 64'((g + 1) * 16));
            if (k == 4) reqValid0 = 4'b0000;
            tick();
        end

        // Operand hold: requester changes its operands after the grant.
        modelLat0 = 20;
        reqA0[1*32 +: 32] = 32'h1234_5678;
        reqB0[1*32 +: 32] = 32'h0000_0002;
        reqValid0 = 4'b0010;
        #1;
        checkOutput("hold grant", 64'(reqReady0), 64'b0010);
        tick();
        reqValid0 = 4'b0000;
        reqA0[1*32 +: 32] = 32'hDEAD_BEEF;
        reqB0[1*32 +: 32] = 32'h0000_0005;
        held = 1'b1;
        n = 0;
        while (rspValid0 !== 1'b1 && n < 200) begin
            if (mulA0 !== 32'h1234_5678 || mulB0 !== 32'h0000_0002) held = 1'b0;
            tick();
            n++;
        end
        checkOutput("operands held", 64'(held), 64'd1);
        checkOutput("hold rsp arrives", 64'(rspValid0), 64'd1);
        checkOutput("hold product", rspP0, 64'h0000_0000_2468_ACF0);
        checkOutput("hold latency", 64'(rspLat0), 64'd20);
        checkOutput("hold rsp id", 64'(rspId0), 64'd1);
        tick();

        // Latency saturation on the 4-bit counter instance.
        modelLat1 = 40;
        reqA1[31:0] = 32'h0001_0000;
        reqB1[31:0] = 32'h0001_0000;
        reqValid1 = 4'b0001;
        #1;
        checkOutput("sat grant", 64'(reqReady1), 64'b0001);
        tick();
        reqValid1 = 4'b0000;
        waitRsp1(n);
        checkOutput("sat latency", 64'(rspLat1), 64'hF);
        checkOutput("sat product", rspP1, 64'h0000_0001_0000_0000);
        checkOutput("sat rsp id", 64'(rspId1), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
